sp_ram8x16_frame_ctrl: RTL
==========================

Name: sp_ram8x16_frame_ctrl

Overview:
Frame buffer controller that sits directly in front of, and around, the sp_ram8x16 single-port synchronous RAM. It accepts a stream of 16-bit samples over a valid/ready handshake and writes each frame of DEPTH samples to sequential RAM addresses. It then reads the frame back in address order and presents it on a valid/ready output stream. It drives the RAM's addr/d_in/we and consumes its d_out.

Parameters:
DW, 16, sample/RAM data width
AW, 3, RAM address width
DEPTH, 8, samples per frame (must equal 2**AW)

Ports:
wclk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept an input sample
s_data  in  DW  input sample
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts output sample
m_data  out  DW  output sample
ram_addr  out  AW  to RAM addr
ram_din  out  DW  to RAM d_in
ram_we  out  1  to RAM we (1 = write)
ram_dout  in  DW  from RAM d_out (registered inside RAM, 1-cycle read latency)
busy  out  1  high in any state except FILL with wr_ptr==0
frames_done  out  8  count of fully drained frames, wraps 255->0

Behaviour:
- One clock (wclk). Reset is asynchronous and active-high (rst).
- All RAM-side outputs are registered.
- Reset values: state=FILL, wr_ptr=0, rd_ptr=0, s_ready=1, m_valid=0, m_data=0, ram_addr=0, ram_din=0, ram_we=0, busy=0, frames_done=0.
- FSM states: FILL, FLUSH, RD_WAIT, RD_CAPT, OUT.
- FILL:
  - s_ready=1.
  - Accept on s_valid&&s_ready at edge e: ram_addr<=wr_ptr, ram_din<=s_data, ram_we<=1. The RAM writes at edge e+1.
  - Cycles with no accept drive ram_we<=0.
  - wr_ptr increments per accept.
  - On the accept with wr_ptr==DEPTH-1: wr_ptr<=0, go to FLUSH.
- FLUSH (one cycle, lets the last write land):
  - s_ready=0.
  - ram_we<=0, ram_addr<=0, rd_ptr<=0, go to RD_WAIT.
- RD_WAIT: the RAM registers d_out for ram_addr. Go to RD_CAPT.
- RD_CAPT: m_data<=ram_dout, m_valid<=1, go to OUT.
- OUT:
  - Hold m_valid and m_data stable while m_ready=0.
  - On m_valid&&m_ready: m_valid<=0.
  - If rd_ptr==DEPTH-1: rd_ptr<=0, frames_done<=frames_done+1, go to FILL (s_ready=1 next cycle).
  - Else: rd_ptr<=rd_ptr+1, ram_addr<=rd_ptr+1, go to RD_WAIT.
- Throughput:
  - Fill: 1 sample/cycle.
  - Drain: 1 sample per 3 cycles with m_ready held high.
  - First m_valid appears 4 cycles after the 8th input accept.
- s_ready is low in FLUSH/RD_WAIT/RD_CAPT/OUT. s_valid in those states is ignored, and the upstream source must hold its data.
- ram_we is never 1 outside the cycle following a FILL accept. No read and write to the RAM overlap.
- Pointer arithmetic is modulo DEPTH. The frames_done counter wraps modulo 256.
- s_data is passed to the RAM unmodified. Drained data equals written data, bit-exact and in address order 0..DEPTH-1.
- Reset mid-operation:
  - Immediately returns every output to its reset value.
  - Any partial frame is discarded; RAM contents are not cleared.
  - The next frame starts at address 0.
- Simultaneous s_valid and m_ready: only the one relevant to the current state has effect.

Test Plan:
- Assert rst for 3 cycles with random inputs -> s_ready=1, m_valid=0, ram_we=0, ram_addr=0, frames_done=0 throughout, and immediately on rst rising (async).
- Stream 0x0001..0x0008 back-to-back, m_ready=1 -> ram_we pulses 8 consecutive cycles at addr 0..7. m_data sequence is 0x0001..0x0008, each m_valid exactly 1 cycle, 3 cycles apart. frames_done=1, then s_ready=1.
- Same frame 0xA5A5,0xFFFF,0x0000,0x8000,0x7FFF,0x1234,0xBEEF,0x0F0F, with m_ready low for 5 cycles on the 3rd output -> m_data=0x0000 held stable 5 cycles. All 8 values emerge in order with no loss or duplication.
- s_valid toggled 1/0 during fill, and s_valid=1 during drain -> only 8 accepts recorded, ram_addr only increments on accepts, s_ready=0 throughout drain.
- Accept 5 samples, pulse rst mid-fill, then send 0x0100..0x0107 -> output sequence is exactly 0x0100..0x0107 and frames_done=1.
- Run 256 frames -> frames_done reads 255 after frame 255 and wraps to 0 after frame 256. Data remains correct across the wrap.

Source files
------------

// File: rtl/sp_ram8x16_frame_ctrl_if.sv
// Sample stream bundle for the frame buffer controller: input stream (s_*) and output stream (m_*).
// The master side is the environment (source and sink); the slave side is the controller.
interface sp_ram8x16_frame_ctrl_if #(
  parameter int unsigned DW = 16
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/sp_ram8x16_frame_ctrl.sv
// Frame buffer controller around a single-port RAM: fills DEPTH samples at sequential addresses,
// then drains them back in address order through a valid/ready output stream.
module sp_ram8x16_frame_ctrl #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          wclk,
  input  logic                          rst,
  sp_ram8x16_frame_ctrl_if.slave        bus,
  output logic [AW-1:0]                 ram_addr,
  output logic [DW-1:0]                 ram_din,
  output logic                          ram_we,
  input  logic [DW-1:0]                 ram_dout,
  output logic                          busy,
  output logic [7:0]                    frames_done
);

  typedef enum logic [2:0] {
    StFill,
    StFlush,
    StRdWait,
    StRdCapt,
    StOut
  } state_e;

  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [7:0]    frames_q, frames_d;

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q    <= StFill;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      frames_q   <= frames_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    // Write strobe is a one-cycle pulse following each accept
    ram_we_d   = 1'b0;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    frames_d   = frames_q;

    unique case (state_q)
      StFill: begin
        if (bus.s_valid) begin
          ram_addr_d = wr_ptr_q;
          ram_din_d  = bus.s_data;
          ram_we_d   = 1'b1;
          if (wr_ptr_q == LastPtr) begin
            wr_ptr_d = '0;
            state_d  = StFlush;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      StFlush: begin
        ram_addr_d = '0;
        rd_ptr_d   = '0;
        state_d    = StRdWait;
      end
      StRdWait: begin
        state_d = StRdCapt;
      end
      StRdCapt: begin
        m_data_d  = ram_dout;
        m_valid_d = 1'b1;
        state_d   = StOut;
      end
      StOut: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          if (rd_ptr_q == LastPtr) begin
            rd_ptr_d = '0;
            frames_d = frames_q + 8'd1;
            state_d  = StFill;
          end else begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            ram_addr_d = rd_ptr_q + AW'(1);
            state_d    = StRdWait;
          end
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  assign bus.s_ready  = (state_q == StFill);
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;
  assign ram_we       = ram_we_q;
  assign frames_done  = frames_q;
  assign busy         = !((state_q == StFill) && (wr_ptr_q == '0));

endmodule
